// File: rtl/alu_pipe_hs.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift ops plus a
// multi-cycle shift-add multiplier, with a registered valid/ready output stage.
module alu_pipe_hs #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_HOLD} state_t;

   state_t              r_state;
   logic                r_alive;
   logic                r_out_valid;
   logic [WIDTH-1:0]    r_result;
   logic [WIDTH-1:0]    r_result_hi;
   logic                r_carry;
   logic                r_zero;
   logic                r_negative;
   logic                r_overflow;
   logic [2*WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [2*WIDTH-1:0]  r_acc;
   logic [CW-1:0]       r_cnt;

   logic [WIDTH:0]      w_sum;
   logic [WIDTH:0]      w_diff;
   logic [WIDTH:0]      w_shl;
   logic [WIDTH:0]      w_shr;
   logic [SHW-1:0]      w_amt;
   logic                w_amt_big;
   logic [WIDTH-1:0]    w_res;
   logic                w_cy;
   logic                w_ov;
   logic                w_accept;
   logic [2*WIDTH-1:0]  w_acc_next;

   assign w_sum      = {1'b0, a} + {1'b0, b};
   assign w_diff     = {1'b0, a} - {1'b0, b};
   assign w_amt      = b[SHW-1:0];
   assign w_amt_big  = ({{(32-SHW){1'b0}}, w_amt} >= 32'(WIDTH));
   // Extra bit on the outgoing side captures the last bit shifted out.
   assign w_shl      = {1'b0, a} << w_amt;
   assign w_shr      = {a, 1'b0} >> w_amt;
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   assign in_ready = r_alive && (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_res = '0;
      w_cy  = 1'b0;
      w_ov  = 1'b0;
      case (op)
         3'b000: w_res = a & b;
         3'b001: w_res = a | b;
         3'b010: w_res = a ^ b;
         3'b011: begin
            w_res = w_sum[WIDTH-1:0];
            w_cy  = w_sum[WIDTH];
            w_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         3'b100: begin
            w_res = w_diff[WIDTH-1:0];
            w_cy  = w_diff[WIDTH];
            w_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         3'b101: if (!w_amt_big) {w_cy, w_res} = w_shl;
         3'b110: if (!w_amt_big) {w_res, w_cy} = w_shr;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_alive     <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
         r_overflow  <= 1'b0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
      end else begin
         r_alive <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept && (op == OP_MUL)) begin
                  r_mcand     <= {{WIDTH{1'b0}}, a};
                  r_mplier    <= b;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_out_valid <= 1'b0;
                  r_state     <= S_MUL_RUN;
               end else if (w_accept) begin
                  r_result    <= w_res;
                  r_result_hi <= '0;
                  r_carry     <= w_cy;
                  r_zero      <= (w_res == '0);
                  r_negative  <= w_res[WIDTH-1];
                  r_overflow  <= w_ov;
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_MUL_RUN: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_result    <= w_acc_next[WIDTH-1:0];
                  r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_carry     <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_zero      <= (w_acc_next == '0);
                  r_negative  <= w_acc_next[2*WIDTH-1];
                  r_overflow  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign carry_out = r_carry;
   assign zero      = r_zero;
   assign negative  = r_negative;
   assign overflow  = r_overflow;
endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_alu_pipe_hs;
   localparam int W   = 8;
   localparam int SHW = $clog2(W);

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         cy;
      logic         z;
      logic         n;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry_out;
   logic         zero;
   logic         negative;
   logic         overflow;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn = 0;
   bit rnd_ready = 1'b0;

   alu_pipe_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .carry_out(carry_out),
      .zero(zero), .negative(negative), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the operation definitions.
   function automatic exp_t ref_calc(input logic [2:0] f_op, input logic [W-1:0] f_a, input logic [W-1:0] f_b);
      exp_t   e;
      longint ua, ub, r, p, sa, sb, s;
      longint m;
      int     amt;
      m   = longint'(1) << W;
      ua  = longint'(f_a);
      ub  = longint'(f_b);
      sa  = (ua >= m / 2) ? ua - m : ua;
      sb  = (ub >= m / 2) ? ub - m : ub;
      amt = int'(ub % longint'(1 << SHW));
      e   = '0;
      r   = 0;
      case (f_op)
         3'd0: r = ua & ub;
         3'd1: r = ua | ub;
         3'd2: r = ua ^ ub;
         3'd3: begin
            r = (ua + ub) % m;
            e.cy = (ua + ub) >= m;
            s = sa + sb;
            e.v = (s >= m / 2) || (s < -(m / 2));
         end
         3'd4: begin
            r = (ua - ub + m) % m;
            e.cy = ua < ub;
            s = sa - sb;
            e.v = (s >= m / 2) || (s < -(m / 2));
         end
         3'd5: begin
            if (amt == 0) r = ua;
            else if (amt >= W) r = 0;
            else begin
               r = (ua << amt) % m;
               e.cy = ((ua >> (W - amt)) & 1) == 1;
            end
         end
         3'd6: begin
            if (amt == 0) r = ua;
            else if (amt >= W) r = 0;
            else begin
               r = ua >> amt;
               e.cy = ((ua >> (amt - 1)) & 1) == 1;
            end
         end
         default: begin
            p = ua * ub;
            r = p % m;
            e.hi = W'(p / m);
            e.cy = (p / m) != 0;
         end
      endcase
      e.res = W'(r);
      if (f_op == 3'd7) begin
         e.z = (ua * ub) == 0;
         e.n = e.hi[W-1];
      end else begin
         e.z = (r == 0);
         e.n = e.res[W-1];
      end
      return e;
   endfunction

   // Transaction-level model: what should be visible at the output and when.
   logic m_alive, m_valid, m_is_mul;
   int   m_mul_left;
   exp_t m_out, m_pend;
   logic m_in_ready;

   assign m_in_ready = m_alive && (m_mul_left == 0) && !(m_valid && m_is_mul) && (!m_valid || out_ready);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_alive    <= 1'b0;
         m_valid    <= 1'b0;
         m_is_mul   <= 1'b0;
         m_mul_left <= 0;
      end else begin
         m_alive <= 1'b1;
         if (in_valid && m_in_ready) begin
            n_txn <= n_txn + 1;
            $display("txn %0d: op=%0d a=%02h b=%02h", n_txn, op, a, b);
            if (op == 3'd7) begin
               m_valid    <= 1'b0;
               m_mul_left <= W;
               m_pend     <= ref_calc(op, a, b);
            end else begin
               m_valid  <= 1'b1;
               m_is_mul <= 1'b0;
               m_out    <= ref_calc(op, a, b);
            end
         end else if (m_mul_left > 0) begin
            m_mul_left <= m_mul_left - 1;
            if (m_mul_left == 1) begin
               m_valid  <= 1'b1;
               m_is_mul <= 1'b1;
               m_out    <= m_pend;
            end
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 64'(in_ready), 64'(m_in_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("result", 64'(result), 64'(m_out.res));
         chk("result_hi", 64'(result_hi), 64'(m_out.hi));
         chk("carry_out", 64'(carry_out), 64'(m_out.cy));
         chk("zero", 64'(zero), 64'(m_out.z));
         chk("negative", 64'(negative), 64'(m_out.n));
         chk("overflow", 64'(overflow), 64'(m_out.v));
      end
      if (!rst_n) begin
         chk("rst_result", 64'(result), 64'h0);
         chk("rst_result_hi", 64'(result_hi), 64'h0);
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic issue(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b);
      bit go;
      in_valid = 1'b1;
      op = t_op;
      a = t_a;
      b = t_b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         go = m_in_ready;
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
         if (go) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: op=%0d not accepted within 200 cycles", t_op);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'h0);
      chk("reset_out_valid", 64'(out_valid), 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_in_ready", 64'(in_ready), 64'h1);
      out_ready = 1'b1;

      issue(3'd3, 8'hFF, 8'h01);
      @(negedge clk);
      chk("add_valid", 64'(out_valid), 64'h1);
      chk("add_result", 64'(result), 64'h00);
      chk("add_carry", 64'(carry_out), 64'h1);
      chk("add_zero", 64'(zero), 64'h1);
      chk("add_ovf", 64'(overflow), 64'h0);
      chk("add_neg", 64'(negative), 64'h0);
      tick();

      issue(3'd4, 8'h80, 8'h01);
      @(negedge clk);
      chk("sub1_result", 64'(result), 64'h7F);
      chk("sub1_carry", 64'(carry_out), 64'h0);
      chk("sub1_ovf", 64'(overflow), 64'h1);
      chk("sub1_neg", 64'(negative), 64'h0);
      tick();
      issue(3'd4, 8'h01, 8'h02);
      @(negedge clk);
      chk("sub2_result", 64'(result), 64'hFF);
      chk("sub2_carry", 64'(carry_out), 64'h1);
      chk("sub2_neg", 64'(negative), 64'h1);
      tick();

      issue(3'd5, 8'h81, 8'h01);
      @(negedge clk);
      chk("shl_result", 64'(result), 64'h02);
      chk("shl_carry", 64'(carry_out), 64'h1);
      tick();
      issue(3'd6, 8'h81, 8'h00);
      @(negedge clk);
      chk("shr0_result", 64'(result), 64'h81);
      chk("shr0_carry", 64'(carry_out), 64'h0);
      tick();

      issue(3'd7, 8'hFF, 8'hFF);
      for (int j = 0; j < W; j++) begin
         @(negedge clk);
         chk("mul_busy_in_ready", 64'(in_ready), 64'h0);
         chk("mul_busy_out_valid", 64'(out_valid), 64'h0);
      end
      @(negedge clk);
      chk("mul_valid", 64'(out_valid), 64'h1);
      chk("mul_in_ready", 64'(in_ready), 64'h0);
      chk("mul_result", 64'(result), 64'h01);
      chk("mul_result_hi", 64'(result_hi), 64'hFE);
      chk("mul_carry", 64'(carry_out), 64'h1);
      chk("mul_neg", 64'(negative), 64'h1);
      tick();

      out_ready = 1'b0;
      issue(3'd0, 8'hF0, 8'h3C);
      in_valid = 1'b1;
      op = 3'd1;
      a = 8'h0F;
      b = 8'hF0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("bp_result", 64'(result), 64'h30);
         chk("bp_out_valid", 64'(out_valid), 64'h1);
         chk("bp_in_ready", 64'(in_ready), 64'h0);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_or_result", 64'(result), 64'hFF);
      chk("bp_or_valid", 64'(out_valid), 64'h1);
      tick();

      issue(3'd7, 8'h0F, 8'h11);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'h0);
      chk("midrst_result", 64'(result), 64'h0);
      chk("midrst_result_hi", 64'(result_hi), 64'h0);
      chk("midrst_in_ready", 64'(in_ready), 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_release_in_ready", 64'(in_ready), 64'h1);
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         chk("no_stale_valid", 64'(out_valid), 64'h0);
      end
      tick();
      issue(3'd3, 8'h02, 8'h03);
      @(negedge clk);
      chk("post_rst_add", 64'(result), 64'h05);
      chk("post_rst_add_valid", 64'(out_valid), 64'h1);
      tick();

      rnd_ready = 1'b1;
      for (int t = 0; t < 250; t++) begin
         issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               tick();
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      repeat (W + 4) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
